vram_arbiter: RTL and testbench

- Shares the single-port synchronous VRAM between two requesters: display scanout (pixel fetch) and CPU bus (read/write).
- Scanout has hard priority during active pixels. CPU accesses are buffered and granted in free cycles.
- A starvation counter exposes how long the CPU has waited.
- Sits between the scanout address generator, the CPU memory bus decoder and the VRAM block RAM.

---
 rtl/vram_arbiter_pkg.sv | 17 +
 rtl/vram_arbiter_if.sv | 41 ++++
 rtl/vram_disp_pipe.sv | 44 ++++
 rtl/vram_arbiter.sv | 140 ++++++++++++++
 tb/tb_vram_arbiter.sv | 376 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vram_arbiter_pkg.sv
// Shared types and default widths for the VRAM arbiter and its neighbours.
// The CPU access FSM state encoding lives here so bench and tools see one definition.
package vram_arbiter_pkg;

   localparam int unsigned VRAM_ADDR_W = 16;
   localparam int unsigned VRAM_DATA_W = 16;
   localparam int unsigned VRAM_WAIT_W = 10;

   typedef enum logic [2:0] {
      StIdle,
      StPend,
      StGrant,
      StRead,
      StDone
   } cpu_state_e;

endpackage

// File: rtl/vram_arbiter_if.sv
// CPU-side VRAM bus: level request held until a one-cycle ack, plus wait-time telemetry.
interface vram_arbiter_if
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = VRAM_ADDR_W,
   parameter int unsigned DATA_W = VRAM_DATA_W,
   parameter int unsigned WAIT_W = VRAM_WAIT_W
);

   logic              cpu_req;
   logic              cpu_we;
   logic [ADDR_W-1:0] cpu_addr;
   logic [1:0]        cpu_be;
   logic [DATA_W-1:0] cpu_wdata;
   logic              cpu_ack;
   logic [DATA_W-1:0] cpu_rdata;
   logic [WAIT_W-1:0] cpu_wait;

   modport master (
      output cpu_req,
      output cpu_we,
      output cpu_addr,
      output cpu_be,
      output cpu_wdata,
      input  cpu_ack,
      input  cpu_rdata,
      input  cpu_wait
   );

   modport slave (
      input  cpu_req,
      input  cpu_we,
      input  cpu_addr,
      input  cpu_be,
      input  cpu_wdata,
      output cpu_ack,
      output cpu_rdata,
      output cpu_wait
   );

endinterface

// File: rtl/vram_disp_pipe.sv
// Scanout return path: a request at cycle N shows up as disp_data/disp_valid at N+2,
// regardless of what the CPU side is doing.
module vram_disp_pipe
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned DATA_W = VRAM_DATA_W
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              disp_req,
   input  logic [DATA_W-1:0] vram_rdata,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid
);

   logic              req_d1_q;
   logic              valid_q;
   logic [DATA_W-1:0] data_q;
   logic [DATA_W-1:0] data_d;

   // RAM data belongs to the request issued one cycle ago; otherwise hold last pixel.
   always_comb begin
      data_d = data_q;
      if (req_d1_q) begin
         data_d = vram_rdata;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         req_d1_q <= 1'b0;
         valid_q  <= 1'b0;
         data_q   <= '0;
      end else begin
         req_d1_q <= disp_req;
         valid_q  <= req_d1_q;
         data_q   <= data_d;
      end
   end

   assign disp_data  = data_q;
   assign disp_valid = valid_q;

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: scanout has absolute priority, CPU accesses are latched
// and slipped into free cycles, with a saturating counter of how long the CPU waited.
module vram_arbiter
   import vram_arbiter_pkg::*;
#(
   parameter int unsigned ADDR_W = VRAM_ADDR_W,
   parameter int unsigned DATA_W = VRAM_DATA_W,
   parameter int unsigned WAIT_W = VRAM_WAIT_W
) (
   input  logic              clk,
   input  logic              clrn,
   input  logic              disp_req,
   input  logic [ADDR_W-1:0] disp_addr,
   output logic [DATA_W-1:0] disp_data,
   output logic              disp_valid,
   vram_arbiter_if.slave     cpu,
   output logic [ADDR_W-1:0] vram_addr,
   output logic              vram_we,
   output logic [1:0]        vram_be,
   output logic [DATA_W-1:0] vram_wdata,
   input  logic [DATA_W-1:0] vram_rdata
);

   cpu_state_e        state_q, state_d;
   logic              lat_we_q;
   logic [ADDR_W-1:0] lat_addr_q;
   logic [1:0]        lat_be_q;
   logic [DATA_W-1:0] lat_wdata_q;
   logic              latch_en;
   logic [DATA_W-1:0] rdata_q, rdata_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic              just_done_q;

   always_comb begin
      state_d  = state_q;
      wait_d   = wait_q;
      rdata_d  = rdata_q;
      latch_en = 1'b0;
      unique case (state_q)
         StIdle: begin
            wait_d = '0;
            // Skip the cycle right after an ack so a still-held request is not re-serviced.
            if (cpu.cpu_req && !just_done_q) begin
               latch_en = 1'b1;
               state_d  = StPend;
            end
         end
         StPend: begin
            if (wait_q != '1) begin
               wait_d = wait_q + 1'b1;
            end
            if (!disp_req) begin
               state_d = StGrant;
            end
         end
         StGrant: begin
            if (disp_req) begin
               state_d = StPend;
            end else if (lat_we_q) begin
               state_d = StDone;
            end else begin
               state_d = StRead;
            end
         end
         StRead: begin
            rdata_d = vram_rdata;
            state_d = StDone;
         end
         StDone: begin
            wait_d  = '0;
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state_q     <= StIdle;
         wait_q      <= '0;
         rdata_q     <= '0;
         just_done_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wait_q      <= wait_d;
         rdata_q     <= rdata_d;
         just_done_q <= (state_q == StDone);
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_be_q    <= '0;
         lat_wdata_q <= '0;
      end else if (latch_en) begin
         lat_we_q    <= cpu.cpu_we;
         lat_addr_q  <= cpu.cpu_addr;
         lat_be_q    <= cpu.cpu_be;
         lat_wdata_q <= cpu.cpu_wdata;
      end
   end

   // Port mux; scanout overrides a GRANT in the same cycle, and reset forces the port quiet.
   always_comb begin
      vram_addr  = '0;
      vram_we    = 1'b0;
      vram_be    = '0;
      vram_wdata = '0;
      if (!clrn) begin
         vram_addr = '0;
      end else if (disp_req) begin
         vram_addr = disp_addr;
      end else if (state_q == StGrant) begin
         vram_addr  = lat_addr_q;
         vram_we    = lat_we_q;
         vram_be    = lat_be_q;
         vram_wdata = lat_wdata_q;
      end
   end

   assign cpu.cpu_ack   = (state_q == StDone);
   assign cpu.cpu_rdata = rdata_q;
   assign cpu.cpu_wait  = wait_q;

   vram_disp_pipe #(
      .DATA_W (DATA_W)
   ) u_disp_pipe (
      .clk        (clk),
      .clrn       (clrn),
      .disp_req   (disp_req),
      .vram_rdata (vram_rdata),
      .disp_data  (disp_data),
      .disp_valid (disp_valid)
   );

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter with a behavioural byte-enable VRAM model.
module tb_vram_arbiter;
   import vram_arbiter_pkg::*;

   localparam int unsigned AW = 16;
   localparam int unsigned DW = 16;
   localparam int unsigned WW = 10;

   logic          clk = 1'b0;
   logic          clrn = 1'b0;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic [AW-1:0] vram_addr;
   logic          vram_we;
   logic [1:0]    vram_be;
   logic [DW-1:0] vram_wdata;
   logic [DW-1:0] vram_rdata;

   always #5 clk = ~clk;

   vram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW), .WAIT_W(WW)) cpu_bus ();

   vram_arbiter #(
      .ADDR_W (AW),
      .DATA_W (DW),
      .WAIT_W (WW)
   ) dut (
      .clk        (clk),
      .clrn       (clrn),
      .disp_req   (disp_req),
      .disp_addr  (disp_addr),
      .disp_data  (disp_data),
      .disp_valid (disp_valid),
      .cpu        (cpu_bus),
      .vram_addr  (vram_addr),
      .vram_we    (vram_we),
      .vram_be    (vram_be),
      .vram_wdata (vram_wdata),
      .vram_rdata (vram_rdata)
   );

   function automatic logic [15:0] pat(input logic [15:0] a);
      return (a * 16'd7) ^ 16'hA5C3;
   endfunction

   // VRAM model, preloaded with pat() on the first clock edge.
   logic [DW-1:0] mem [0:65535];
   logic          ram_ready = 1'b0;
   always @(posedge clk) begin
      if (!ram_ready) begin
         for (int i = 0; i < 65536; i++) mem[i] <= pat(16'(i));
         ram_ready  <= 1'b1;
         vram_rdata <= '0;
      end else begin
         if (vram_we && vram_be[0]) mem[vram_addr][7:0] <= vram_wdata[7:0];
         if (vram_we && vram_be[1]) mem[vram_addr][15:8] <= vram_wdata[15:8];
         vram_rdata <= mem[vram_addr];
      end
   end

   // Any cycle where scanout asks but the port is not purely scanout is a violation.
   int viol = 0;
   int wr4000 = 0;
   always @(negedge clk) begin
      if (clrn && disp_req && (vram_we || vram_addr != disp_addr)) viol <= viol + 1;
      if (vram_we && vram_addr == 16'h4000) wr4000 <= wr4000 + 1;
   end

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Runs one CPU access with idle scanout; cycle 0 is the cycle cpu_req is first seen.
   task automatic cpu_xfer(input logic we, input logic [15:0] addr, input logic [1:0] be,
                           input logic [15:0] wd, input bit hold, output int ack_cyc,
                           output logic [15:0] rd, output int we_cyc, output int we_at);
      disp_req          = 1'b0;
      cpu_bus.cpu_we    = we;
      cpu_bus.cpu_addr  = addr;
      cpu_bus.cpu_be    = be;
      cpu_bus.cpu_wdata = wd;
      cpu_bus.cpu_req   = 1'b1;
      ack_cyc = -1;
      rd      = '0;
      we_cyc  = 0;
      we_at   = -1;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (vram_we) begin
            we_cyc++;
            we_at = c;
         end
         if (cpu_bus.cpu_ack) begin
            ack_cyc = c;
            rd      = cpu_bus.cpu_rdata;
         end
         step();
         if (!hold) cpu_bus.cpu_req = 1'b0;
         if (ack_cyc >= 0) break;
      end
      cpu_bus.cpu_req = 1'b0;
      step();
   endtask

   int            ack, wc, wa, acks, k, cnt, first, last, gap, wr_before;
   logic [15:0]   rd, exp_last;
   bit            h_req [0:301];
   logic [15:0]   h_addr [0:301];
   int            n;

   initial begin
      disp_req          = 1'b1;
      disp_addr         = 16'h0055;
      cpu_bus.cpu_req   = 1'b1;
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 16'h0001;
      cpu_bus.cpu_be    = 2'b11;
      cpu_bus.cpu_wdata = 16'h1111;
      #2;
      check("rst_disp_data", 32'(disp_data), 32'h0);
      check("rst_disp_valid", 32'(disp_valid), 32'h0);
      check("rst_ack", 32'(cpu_bus.cpu_ack), 32'h0);
      check("rst_rdata", 32'(cpu_bus.cpu_rdata), 32'h0);
      check("rst_wait", 32'(cpu_bus.cpu_wait), 32'h0);
      check("rst_vram_addr", 32'(vram_addr), 32'h0);
      check("rst_vram_we", 32'(vram_we), 32'h0);
      check("rst_vram_be", 32'(vram_be), 32'h0);
      check("rst_vram_wdata", 32'(vram_wdata), 32'h0);
      disp_req        = 1'b0;
      disp_addr       = '0;
      cpu_bus.cpu_req = 1'b0;
      repeat (3) step();
      clrn = 1'b1;
      step();

      // Full-word write then read-back, idle scanout.
      cpu_xfer(1'b1, 16'h1234, 2'b11, 16'hBEEF, 1'b1, ack, rd, wc, wa);
      check("wr_ack_cycle", 32'(ack), 32'd3);
      check("wr_we_count", 32'(wc), 32'd1);
      check("wr_we_cycle", 32'(wa), 32'd2);
      cpu_xfer(1'b0, 16'h1234, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("rd_ack_cycle", 32'(ack), 32'd4);
      check("rd_data", 32'(rd), 32'hBEEF);
      check("rd_we_count", 32'(wc), 32'd0);

      // Byte enables.
      cpu_xfer(1'b1, 16'h2000, 2'b11, 16'hFFFF, 1'b1, ack, rd, wc, wa);
      cpu_xfer(1'b1, 16'h2000, 2'b01, 16'hAA55, 1'b1, ack, rd, wc, wa);
      cpu_xfer(1'b0, 16'h2000, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("be01_data", 32'(rd), 32'hFF55);
      cpu_xfer(1'b1, 16'h2000, 2'b00, 16'h1111, 1'b1, ack, rd, wc, wa);
      check("be00_ack_cycle", 32'(ack), 32'd3);
      cpu_xfer(1'b0, 16'h2000, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("be00_unchanged", 32'(rd), 32'hFF55);

      // Scanout 0..239 in 16-on/4-off bursts with CPU writes held in the gaps.
      acks              = 0;
      k                 = 0;
      n                 = 0;
      exp_last          = 16'h0000;
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_be    = 2'b11;
      cpu_bus.cpu_addr  = 16'h9000;
      cpu_bus.cpu_wdata = 16'h7000;
      cpu_bus.cpu_req   = 1'b1;
      for (int c = 0; c < 302; c++) begin
         h_req[c]  = (c < 300) && ((c % 20) < 16);
         h_addr[c] = 16'(n);
         disp_req  = h_req[c];
         disp_addr = h_req[c] ? 16'(n) : 16'h0000;
         if (h_req[c]) n++;
         @(negedge clk);
         if (c >= 2) begin
            if (h_req[c-2]) exp_last = pat(h_addr[c-2]);
            check("stream_valid", 32'(disp_valid), 32'(h_req[c-2]));
            check("stream_data", 32'(disp_data), 32'(exp_last));
         end
         if (cpu_bus.cpu_ack) acks++;
         step();
         if (cpu_bus.cpu_ack === 1'b0 && acks > k) begin
            k = acks;
            cpu_bus.cpu_addr  = 16'h9000 + 16'(k);
            cpu_bus.cpu_wdata = 16'h7000 + 16'(k);
         end
      end
      cpu_bus.cpu_req = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (cpu_bus.cpu_ack) acks++;
         step();
      end
      check("stream_cpu_acks", 32'(acks), 32'd16);
      cpu_xfer(1'b0, 16'h900F, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("stream_last_write", 32'(rd), 32'h700F);
      check("stream_no_cpu_hit", 32'(viol), 32'd0);

      // 240 cycles of scanout starving a CPU read.
      cpu_bus.cpu_we   = 1'b0;
      cpu_bus.cpu_addr = 16'h1234;
      cpu_bus.cpu_req  = 1'b1;
      step();
      cnt = 0;
      for (int i = 0; i < 240; i++) begin
         disp_req  = 1'b1;
         disp_addr = 16'h0100 + 16'(i);
         @(negedge clk);
         if (cpu_bus.cpu_ack) cnt++;
         if (i == 100) check("starve_wait_100", 32'(cpu_bus.cpu_wait), 32'd100);
         step();
      end
      disp_req = 1'b0;
      check("starve_no_ack", 32'(cnt), 32'd0);
      ack = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (j == 0) check("starve_wait_240", 32'(cpu_bus.cpu_wait), 32'd240);
         if (cpu_bus.cpu_ack) begin
            ack = j;
            rd  = cpu_bus.cpu_rdata;
         end
         step();
         if (ack >= 0) break;
      end
      cpu_bus.cpu_req = 1'b0;
      step();
      check("starve_ack_offset", 32'(ack), 32'd3);
      check("starve_rdata", 32'(rd), 32'hBEEF);
      check("starve_no_cpu_hit", 32'(viol), 32'd0);

      // Scanout reclaims the port in the GRANT cycle.
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 16'h5000;
      cpu_bus.cpu_be    = 2'b11;
      cpu_bus.cpu_wdata = 16'h0BAD;
      cpu_bus.cpu_req   = 1'b1;
      disp_req          = 1'b1;
      disp_addr         = 16'h0041;
      step();
      disp_req = 1'b0;
      @(negedge clk);
      check("coll_wait_c0", 32'(cpu_bus.cpu_wait), 32'd0);
      step();
      disp_req  = 1'b1;
      disp_addr = 16'h0042;
      @(negedge clk);
      check("coll_grant_we", 32'(vram_we), 32'd0);
      check("coll_grant_addr", 32'(vram_addr), 32'h0042);
      step();
      @(negedge clk);
      check("coll_pend_we", 32'(vram_we), 32'd0);
      step();
      disp_req = 1'b0;
      step();
      @(negedge clk);
      check("coll_regrant_we", 32'(vram_we), 32'd1);
      check("coll_regrant_addr", 32'(vram_addr), 32'h5000);
      check("coll_wait_c4", 32'(cpu_bus.cpu_wait), 32'd3);
      step();
      @(negedge clk);
      check("coll_ack", 32'(cpu_bus.cpu_ack), 32'd1);
      step();
      cpu_bus.cpu_req = 1'b0;
      step();
      cpu_xfer(1'b0, 16'h5000, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("coll_readback", 32'(rd), 32'h0BAD);

      // Request held high across acks.
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 16'h6000;
      cpu_bus.cpu_wdata = 16'h1111;
      cpu_bus.cpu_req   = 1'b1;
      cnt   = 0;
      first = -1;
      last  = -1;
      gap   = 1000;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (cpu_bus.cpu_ack) begin
            cnt++;
            if (first < 0) first = c;
            if (last >= 0 && (c - last) < gap) gap = c - last;
            last = c;
         end
         step();
      end
      cpu_bus.cpu_req = 1'b0;
      step();
      check("held_ack_count", 32'(cnt), 32'd4);
      check("held_first_ack", 32'(first), 32'd3);
      check("held_min_gap", 32'(gap), 32'd5);

      // Wait counter saturation under 2000 cycles of scanout.
      cpu_bus.cpu_addr  = 16'h6001;
      cpu_bus.cpu_wdata = 16'h2222;
      cpu_bus.cpu_req   = 1'b1;
      step();
      for (int i = 0; i < 2000; i++) begin
         disp_req  = 1'b1;
         disp_addr = 16'(i);
         @(negedge clk);
         if (i == 1023) check("sat_wait_1023", 32'(cpu_bus.cpu_wait), 32'd1023);
         if (i == 1999) check("sat_wait_1999", 32'(cpu_bus.cpu_wait), 32'd1023);
         step();
      end
      disp_req = 1'b0;
      ack = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (cpu_bus.cpu_ack) ack = j;
         step();
         if (ack >= 0) break;
      end
      cpu_bus.cpu_req = 1'b0;
      step();
      check("sat_ack_offset", 32'(ack), 32'd2);

      // Request dropped right after acceptance still completes.
      cpu_xfer(1'b1, 16'h3000, 2'b11, 16'h1357, 1'b0, ack, rd, wc, wa);
      check("drop_ack_cycle", 32'(ack), 32'd3);
      check("drop_we_cycle", 32'(wa), 32'd2);
      cpu_xfer(1'b0, 16'h3000, 2'b11, 16'h0000, 1'b1, ack, rd, wc, wa);
      check("drop_readback", 32'(rd), 32'h1357);

      // Reset while a write sits in PEND behind scanout.
      wr_before         = wr4000;
      cpu_bus.cpu_we    = 1'b1;
      cpu_bus.cpu_addr  = 16'h4000;
      cpu_bus.cpu_wdata = 16'h2468;
      cpu_bus.cpu_req   = 1'b1;
      disp_req          = 1'b1;
      disp_addr         = 16'h0007;
      repeat (6) step();
      clrn = 1'b0;
      #1;
      check("mid_rst_wait", 32'(cpu_bus.cpu_wait), 32'd0);
      check("mid_rst_ack", 32'(cpu_bus.cpu_ack), 32'd0);
      check("mid_rst_rdata", 32'(cpu_bus.cpu_rdata), 32'd0);
      check("mid_rst_disp_valid", 32'(disp_valid), 32'd0);
      check("mid_rst_disp_data", 32'(disp_data), 32'd0);
      check("mid_rst_vram_addr", 32'(vram_addr), 32'd0);
      check("mid_rst_vram_we", 32'(vram_we), 32'd0);
      repeat (2) step();
      disp_req = 1'b0;
      clrn     = 1'b1;
      ack      = -1;
      for (int j = 0; j < 20; j++) begin
         @(negedge clk);
         if (cpu_bus.cpu_ack) ack = j;
         step();
         if (ack >= 0) break;
      end
      cpu_bus.cpu_req = 1'b0;
      repeat (2) step();
      check("mid_rst_ack_offset", 32'(ack), 32'd3);
      check("mid_rst_one_write", 32'(wr4000 - wr_before), 32'd1);
      check("no_cpu_under_scanout", 32'(viol), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
